// File: rtl/candidate_dispatch_if.sv
// Candidate dispatch bus: load/capture controls from the sorter side and the
// valid/ready candidate stream toward the angle-refinement stage.
interface candidate_dispatch_if #(
  parameter int unsigned NUM     = 10,
  parameter int unsigned ANGLE_W = 12
);
  localparam int unsigned BUF_W = NUM * 2 * ANGLE_W;

  logic               load;
  logic [BUF_W-1:0]   candidate_angle_buffer;
  logic [3:0]         cand_num;
  logic               skip_zero;
  logic               cand_ready;
  logic               cand_valid;
  logic [ANGLE_W-1:0] theta;
  logic [ANGLE_W-1:0] phi;
  logic [3:0]         cand_rank;
  logic               busy;
  logic               done;
  logic               load_drop;

  modport master (
    output load, candidate_angle_buffer, cand_num, skip_zero, cand_ready,
    input  cand_valid, theta, phi, cand_rank, busy, done, load_drop
  );

  modport slave (
    input  load, candidate_angle_buffer, cand_num, skip_zero, cand_ready,
    output cand_valid, theta, phi, cand_rank, busy, done, load_drop
  );
endinterface

// File: rtl/candidate_dispatch.sv
// Captures the ranked candidate buffer on load and streams slots highest-rank
// first over valid/ready, optionally skipping all-zero slots.
module candidate_dispatch #(
  parameter int unsigned NUM     = 10,
  parameter int unsigned ANGLE_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  candidate_dispatch_if.slave bus
);
  localparam int unsigned SLOT_W = 2 * ANGLE_W;
  localparam int unsigned IDX_W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SLOT_W-1:0]  shadow [NUM];
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   sent, sent_nxt;
  logic [CNT_W-1:0]   target, target_nxt;
  logic               skip_en, skip_en_nxt;
  logic [CNT_W-1:0]   target_req;
  logic [SLOT_W-1:0]  slot;
  logic               capture;
  logic               skip;
  logic               xfer;
  logic               valid;
  logic               drop;

  assign target_req = (bus.cand_num > CNT_W'(NUM)) ? CNT_W'(NUM) : bus.cand_num;
  assign slot       = shadow[idx];

  // Shadow copy is written only on an accepted load, isolating the walk
  // from later changes on the live buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM; k++) shadow[k] <= '0;
    end else if (capture) begin
      for (int unsigned k = 0; k < NUM; k++)
        shadow[k] <= bus.candidate_angle_buffer[k*SLOT_W +: SLOT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      sent    <= '0;
      target  <= '0;
      skip_en <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      sent    <= sent_nxt;
      target  <= target_nxt;
      skip_en <= skip_en_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    sent_nxt    = sent;
    target_nxt  = target;
    skip_en_nxt = skip_en;
    capture     = 1'b0;
    skip        = 1'b0;
    xfer        = 1'b0;
    valid       = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          capture     = 1'b1;
          skip_en_nxt = bus.skip_zero;
          target_nxt  = target_req;
          idx_nxt     = IDX_W'(NUM - 1);
          sent_nxt    = '0;
          state_nxt   = (target_req == '0) ? FIN : SEND;
        end
      end
      SEND: begin
        drop  = bus.load;
        skip  = skip_en && (slot == '0);
        valid = !skip;
        xfer  = valid && bus.cand_ready;
        // Slot 0 consumed (sent or skipped) ends the walk even if short of target.
        if (skip || xfer) begin
          idx_nxt = idx - 1'b1;
          if (idx == '0) state_nxt = FIN;
        end
        if (xfer) begin
          sent_nxt = sent + 1'b1;
          if ((sent + 1'b1) == target) state_nxt = FIN;
        end
      end
      FIN: begin
        drop      = bus.load;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cand_valid = valid;
  assign bus.theta      = slot[SLOT_W-1 -: ANGLE_W];
  assign bus.phi        = slot[ANGLE_W-1:0];
  assign bus.cand_rank  = sent;
  assign bus.busy       = (state == SEND);
  assign bus.done       = (state == FIN);
  assign bus.load_drop  = drop;
endmodule

// File: tb/tb_candidate_dispatch.sv
// Directed self-checking bench for candidate_dispatch.
module tb_candidate_dispatch;
  localparam int unsigned NUM     = 10;
  localparam int unsigned ANGLE_W = 12;
  localparam int unsigned SLOT_W  = 2 * ANGLE_W;
  localparam int unsigned BUF_W   = NUM * SLOT_W;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  candidate_dispatch_if #(.NUM(NUM), .ANGLE_W(ANGLE_W)) bus ();

  candidate_dispatch #(.NUM(NUM), .ANGLE_W(ANGLE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {valid, theta, phi, rank} and {busy, done, load_drop}
  logic [28:0] obs;
  logic [2:0]  stat;
  assign obs  = {bus.cand_valid, bus.theta, bus.phi, bus.cand_rank};
  assign stat = {bus.busy, bus.done, bus.load_drop};

  function automatic logic [BUF_W-1:0] ramp_buf();
    logic [BUF_W-1:0] b;
    b = '0;
    for (int k = 0; k < NUM; k++) b[k*SLOT_W +: SLOT_W] = {12'(k + 1), 12'(256 + k)};
    return b;
  endfunction

  // Expected candidate word for ramp slot k delivered at the given rank.
  function automatic logic [28:0] ramp_exp(input int k, input int rank);
    return {1'b1, 12'(k + 1), 12'(256 + k), 4'(rank)};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic start_load(input logic [BUF_W-1:0] b, input logic [3:0] num, input logic sz);
    bus.candidate_angle_buffer = b;
    bus.cand_num  = num;
    bus.skip_zero = sz;
    bus.load      = 1'b1;
    next_cyc();
    bus.load      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.load = 1'b0; bus.candidate_angle_buffer = '0; bus.cand_num = '0;
    bus.skip_zero = 1'b0; bus.cand_ready = 1'b0;
    next_cyc(); next_cyc();
    mid();
    n_checks++; if (obs !== 29'd0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", obs); end
    n_checks++; if (stat !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b exp 000", stat); end
    next_cyc();
    rst = 1'b1;
    next_cyc();
  endtask

  task automatic test_full_dispatch();
    bus.cand_ready = 1'b1;
    start_load(ramp_buf(), 4'd10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mid();
      n_checks++; if (obs !== ramp_exp(9 - i, i)) begin n_fail++; $display("FAIL full_cand%0d got %h exp %h", i, obs, ramp_exp(9 - i, i)); end
      n_checks++; if (stat !== 3'b100) begin n_fail++; $display("FAIL full_busy%0d got %b exp 100", i, stat); end
      next_cyc();
    end
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0010) begin n_fail++; $display("FAIL full_done got %b exp 0010", {obs[28], stat}); end
    next_cyc();
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0000) begin n_fail++; $display("FAIL full_idle got %b exp 0000", {obs[28], stat}); end
    next_cyc();
  endtask

  task automatic test_partial_clamp();
    bus.cand_ready = 1'b1;
    start_load(ramp_buf(), 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mid();
      n_checks++; if (obs !== ramp_exp(9 - i, i)) begin n_fail++; $display("FAIL partial_cand%0d got %h exp %h", i, obs, ramp_exp(9 - i, i)); end
      next_cyc();
    end
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0010) begin n_fail++; $display("FAIL partial_done got %b exp 0010", {obs[28], stat}); end
    next_cyc();
    start_load(ramp_buf(), 4'd15, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mid();
      n_checks++; if (obs !== ramp_exp(9 - i, i)) begin n_fail++; $display("FAIL clamp_cand%0d got %h exp %h", i, obs, ramp_exp(9 - i, i)); end
      next_cyc();
    end
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0010) begin n_fail++; $display("FAIL clamp_done got %b exp 0010", {obs[28], stat}); end
    next_cyc();
  endtask

  task automatic test_skip_zero();
    logic [BUF_W-1:0] z;
    int xfers;
    z = '0;
    z[9*SLOT_W +: SLOT_W] = {12'hA5A, 12'h123};
    z[7*SLOT_W +: SLOT_W] = {12'h777, 12'h070};
    xfers = 0;
    bus.cand_ready = 1'b1;
    start_load(z, 4'd5, 1'b1);
    for (int c = 0; c < 10; c++) begin
      mid();
      if (bus.cand_valid && bus.cand_ready) xfers++;
      if (c == 0) begin
        n_checks++; if (obs !== {1'b1, 12'hA5A, 12'h123, 4'd0}) begin n_fail++; $display("FAIL skip_slot9 got %h", obs); end
      end else if (c == 2) begin
        n_checks++; if (obs !== {1'b1, 12'h777, 12'h070, 4'd1}) begin n_fail++; $display("FAIL skip_slot7 got %h", obs); end
      end else begin
        n_checks++; if ({bus.cand_valid, bus.cand_rank, stat} !== {1'b0, 4'((c < 2) ? 1 : 2), 3'b100}) begin
          n_fail++; $display("FAIL skip_gap%0d got %b", c, {bus.cand_valid, bus.cand_rank, stat});
        end
      end
      next_cyc();
    end
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0010) begin n_fail++; $display("FAIL skip_done got %b exp 0010", {obs[28], stat}); end
    n_checks++; if (xfers !== 2) begin n_fail++; $display("FAIL skip_count got %0d exp 2", xfers); end
    next_cyc();
  endtask

  task automatic test_backpressure();
    logic pat [4];
    logic [11:0] prev_theta;
    logic prev_stall;
    int sent_m;
    int c;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent_m = 0; c = 0; prev_stall = 1'b0; prev_theta = '0;
    bus.cand_ready = 1'b1;
    start_load(ramp_buf(), 4'd4, 1'b0);
    while (sent_m < 4 && c < 20) begin
      bus.cand_ready = pat[c % 4];
      mid();
      n_checks++; if (obs !== ramp_exp(9 - sent_m, sent_m)) begin n_fail++; $display("FAIL bp_cyc%0d got %h exp %h", c, obs, ramp_exp(9 - sent_m, sent_m)); end
      if (prev_stall) begin
        n_checks++; if (bus.theta !== prev_theta) begin n_fail++; $display("FAIL bp_hold%0d got %h exp %h", c, bus.theta, prev_theta); end
      end
      prev_theta = bus.theta;
      prev_stall = !bus.cand_ready;
      if (bus.cand_ready) sent_m++;
      next_cyc();
      c++;
    end
    n_checks++; if (sent_m !== 4) begin n_fail++; $display("FAIL bp_timeout got %0d exp 4", sent_m); end
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0010) begin n_fail++; $display("FAIL bp_done got %b exp 0010", {obs[28], stat}); end
    next_cyc();
    bus.cand_ready = 1'b1;
  endtask

  task automatic test_target_zero();
    start_load(ramp_buf(), 4'd0, 1'b0);
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0010) begin n_fail++; $display("FAIL zero_done got %b exp 0010", {obs[28], stat}); end
    next_cyc();
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0000) begin n_fail++; $display("FAIL zero_idle got %b exp 0000", {obs[28], stat}); end
    next_cyc();
  endtask

  task automatic test_load_drop();
    bus.cand_ready = 1'b1;
    start_load(ramp_buf(), 4'd10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.load = (i == 1);
      if (i == 1) begin bus.cand_num = 4'd2; bus.candidate_angle_buffer = '1; end
      mid();
      n_checks++; if (obs !== ramp_exp(9 - i, i)) begin n_fail++; $display("FAIL drop_cand%0d got %h exp %h", i, obs, ramp_exp(9 - i, i)); end
      if (i < 3) begin
        n_checks++; if (stat !== {1'b1, 1'b0, (i == 1)}) begin n_fail++; $display("FAIL drop_flag%0d got %b", i, stat); end
      end
      next_cyc();
    end
    bus.load = 1'b1;
    mid();
    n_checks++; if (stat !== 3'b011) begin n_fail++; $display("FAIL drop_in_fin got %b exp 011", stat); end
    next_cyc();
    bus.load = 1'b0;
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0000) begin n_fail++; $display("FAIL drop_idle got %b exp 0000", {obs[28], stat}); end
    next_cyc();
  endtask

  task automatic test_isolation();
    bus.cand_ready = 1'b1;
    start_load(ramp_buf(), 4'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.candidate_angle_buffer = ~ramp_buf() ^ BUF_W'(i);
      mid();
      n_checks++; if (obs !== ramp_exp(9 - i, i)) begin n_fail++; $display("FAIL iso_cand%0d got %h exp %h", i, obs, ramp_exp(9 - i, i)); end
      next_cyc();
    end
    mid();
    n_checks++; if ({obs[28], stat} !== 4'b0010) begin n_fail++; $display("FAIL iso_done got %b exp 0010", {obs[28], stat}); end
    next_cyc();
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    bus.cand_ready = 1'b1;
    start_load(ramp_buf(), 4'd10, 1'b0);
    next_cyc(); next_cyc(); next_cyc();
    rst = 1'b0;
    next_cyc();
    rst = 1'b1;
    mid();
    n_checks++; if (obs !== 29'd0) begin n_fail++; $display("FAIL rstmid_outputs got %h exp 0", obs); end
    n_checks++; if (stat !== 3'b000) begin n_fail++; $display("FAIL rstmid_status got %b exp 000", stat); end
    for (int i = 0; i < 12; i++) begin
      next_cyc();
      mid();
      if (bus.done || bus.cand_valid) seen_done++;
    end
    n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d exp 0", seen_done); end
    next_cyc();
  endtask

  initial begin
    test_reset();
    test_full_dispatch();
    test_partial_clamp();
    test_skip_zero();
    test_backpressure();
    test_target_zero();
    test_load_drop();
    test_isolation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/candidate_dispatch.md
# candidate_dispatch

Reads the ranked candidate-angle buffer produced by the score sorter and streams the candidates one at a time, highest-ranked first, to the downstream angle-refinement stage. A `load` pulse captures the whole buffer. The block then walks it with a valid/ready handshake, optionally skips empty (all-zero) slots, and pulses `done` when the requested number of candidates has been delivered or the buffer is exhausted.

## Interface
Parameters:
- `NUM`, 10: candidate slots in the buffer.
- `ANGLE_W`, 12: width of theta and of phi. A slot is `2*ANGLE_W` bits, `{theta, phi}`.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous active-low reset.
- `load`  in  1: capture request, single-cycle pulse.
- `candidate_angle_buffer`  in  `NUM*2*ANGLE_W`: slot k occupies bits `[24k+23:24k]`. Slot `NUM-1` is the highest score.
- `cand_num`  in  4: number of candidates to deliver, sampled at load. Values above `NUM` are clamped to `NUM`.
- `skip_zero`  in  1: sampled at load; when 1, slots equal to 0 are skipped.
- `cand_ready`  in  1: downstream accepts.
- `cand_valid`  out  1: a candidate is presented.
- `theta`  out  `ANGLE_W`: bits `[23:12]` of the current slot.
- `phi`  out  `ANGLE_W`: bits `[11:0]` of the current slot.
- `cand_rank`  out  4: 0 for the first delivered candidate, incrementing per transfer.
- `busy`  out  1: high in SEND.
- `done`  out  1: one-cycle pulse at the end of a dispatch.
- `load_drop`  out  1: one-cycle pulse when `load` is ignored.

## Operation
- State machine states: IDLE, SEND, FIN.
- IDLE, when `load` is high:
  - Copy the buffer into a shadow register.
  - Latch `skip_zero`.
  - Set `target` = min(`cand_num`, `NUM`), `idx` = `NUM-1`, `sent` = 0.
  - Go to FIN if `target` == 0; otherwise go to SEND.
- SEND, current slot `S` = `shadow[idx]`:
  - Skip: `skip` = latched `skip_zero` AND (`S` == 0).
    - When `skip` is 1: `cand_valid` = 0 and `idx` decrements.
    - Skipping never counts toward `sent`.
  - Transfer: when `skip` is 0, `cand_valid` = 1. A transfer occurs on `cand_valid` & `cand_ready`.
    - On a transfer: `sent`++ and `idx`--.
  - Exit: go to FIN on the cycle where (transfer and `sent+1` == `target`), or where `idx` == 0 is being consumed (by transfer or by skip).
  - Exhaustion: if the buffer runs out first, `done` still fires. Fewer than `target` candidates were delivered in that case.
- FIN: `done` = 1 for one cycle, then go to IDLE unconditionally.
- Shadow isolation: the shadow register is not updated outside IDLE. Changes on `candidate_angle_buffer` during SEND have no effect.
- `load` outside IDLE:
  - Ignored; `load_drop` = 1 on that cycle.
  - Includes `load` in FIN.
- Output values:
  - `theta`/`phi` are driven from `shadow[idx]`.
  - When `cand_valid` = 0 they are don't-care, but they must be held stable while `cand_valid` = 1 and `cand_ready` = 0.
  - `cand_rank` = `sent`.
- Reset:
  - Every output is 0: `cand_valid`, `theta`, `phi`, `cand_rank`, `busy`, `done`, `load_drop`.
  - State returns to IDLE; the shadow register, `idx`, `sent` and `target` are cleared.
  - Reset mid-dispatch aborts without `done`.

## Timing
- Load latency: `load` sampled at edge t → `cand_valid` can be high in cycle t+1.
- Throughput: one candidate per cycle with `cand_ready` held high and no skips.
- Each skipped slot costs exactly one cycle.
- Done timing: final transfer at edge t → `done` high in cycle t+1, IDLE in cycle t+2.
  - A new `load` is accepted from cycle t+2.
- `target` == 0: `load` at t → `done` in cycle t+1, no `cand_valid`.
- Backpressure:
  - `cand_valid` never drops without a transfer.
  - `idx`/`sent` do not change while `cand_valid` & !`cand_ready`.
- `busy` equals (state == SEND). It is low in IDLE and FIN.

## Test plan
- Full dispatch:
  - Stimulus: slots k = {theta=k+1, phi=0x100+k}, `cand_num`=10, `skip_zero`=0, `cand_ready`=1.
  - Response: 10 consecutive valid cycles with theta 10,9,…,1 and `cand_rank` 0..9; `done` one cycle after the last transfer.
- Partial plus clamp:
  - Stimulus: `cand_num`=3 → three transfers, slots 9, 8, 7, then `done`.
  - Stimulus: `cand_num`=15 behaves as 10.
- Skip zeros:
  - Stimulus: slots 9 and 7 nonzero, others 0, `skip_zero`=1, `cand_num`=5.
  - Response: transfers of slot 9, then slot 7 (`cand_rank` 0, 1), with a one-cycle gap for slot 8.
  - Response: `done` after slot 0 is scanned; total 2 transfers.
- Backpressure:
  - Stimulus: `cand_ready` toggles 1,0,0,1.
  - Response: `theta`/`phi` constant during the stalls; no candidate lost or duplicated; `cand_rank` advances only on transfers.
- Corner cases:
  - Stimulus: `cand_num`=0 → `done` the cycle after `load`; `cand_valid` never high.
  - Stimulus: `load` during SEND → `load_drop` pulse; dispatch continues unchanged.
  - Stimulus: `rst`=0 mid-dispatch → all outputs 0 next cycle, no `done`.
- Buffer isolation:
  - Stimulus: change `candidate_angle_buffer` during SEND.
  - Response: delivered values match the buffer captured at `load`.
